// File: rtl/alu_quad_bank_if.sv
// Command/result packet bundle for alu_quad_bank: per lane {command, data1, data2} in,
// {response, data} out.
interface alu_quad_bank_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32
);
    logic [NUM_LANES-1:0][2*DATA_W+1:0] input_packet;
    logic [NUM_LANES-1:0][DATA_W+1:0]   output_packet;

    modport master (output input_packet, input output_packet);
    modport slave  (input input_packet, output output_packet);
endinterface

// File: rtl/alu_quad_bank.sv
// Four independent fixed-latency ALU lanes (ADD / MULTIPLY / AND) with overflow reporting.
// Optional feature macro: ALU_SATURATE_EN (saturate data to all-ones on OVERFLOW).
module alu_quad_bank #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 3
) (
    input  logic           clock,
    input  logic           reset,
    alu_quad_bank_if.slave bus
);
    localparam int PKT_W = 2 * DATA_W + 2;
    localparam int CNT_W = $clog2(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {CMD_NOP = 2'd0, CMD_ADD = 2'd1, CMD_MUL = 2'd2, CMD_AND = 2'd3} cmd_t;
    typedef enum logic [1:0] {RSP_NONE = 2'd0, RSP_SUCCESS = 2'd1, RSP_OVERFLOW = 2'd2} rsp_t;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [PKT_W-1:0]    pkt;
        cmd_t                cmd;
        cmd_t                prev_cmd;
        logic                new_req;

        state_t              state, state_nx;
        logic [CNT_W-1:0]    cnt, cnt_nx;
        cmd_t                op, op_nx;
        logic [DATA_W-1:0]   a, a_nx, b, b_nx;
        logic                pend_v, pend_v_nx;
        logic [PKT_W-1:0]    pend, pend_nx;
        logic [PKT_W-1:0]    prev;
        rsp_t                rsp, rsp_nx;
        logic [DATA_W-1:0]   dat, dat_nx;

        logic                start;
        logic [PKT_W-1:0]    start_pkt;

        logic [DATA_W:0]     sum;
        logic [2*DATA_W-1:0] prod;
        rsp_t                res_rsp;
        logic [DATA_W-1:0]   res_dat;

        assign pkt      = bus.input_packet[l];
        assign cmd      = cmd_t'(pkt[PKT_W-1 -: 2]);
        assign prev_cmd = cmd_t'(prev[PKT_W-1 -: 2]);

        // Level-held commands: only a changed packet or a rise from NOP is a fresh request.
        assign new_req = (cmd != CMD_NOP) && ((pkt != prev) || (prev_cmd == CMD_NOP));

        always_comb begin
            sum     = {1'b0, a} + {1'b0, b};
            prod    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
            res_rsp = RSP_SUCCESS;
            res_dat = a & b;
            case (op)
                CMD_ADD: begin
                    res_dat = sum[DATA_W-1:0];
                    if (sum[DATA_W]) res_rsp = RSP_OVERFLOW;
                end
                CMD_MUL: begin
                    res_dat = prod[DATA_W-1:0];
                    if (prod[2*DATA_W-1:DATA_W] != '0) res_rsp = RSP_OVERFLOW;
                end
                default: ;
            endcase
`ifdef ALU_SATURATE_EN
            if (res_rsp == RSP_OVERFLOW) res_dat = '1;
`endif
        end

        always_comb begin
            state_nx  = state;
            cnt_nx    = cnt;
            op_nx     = op;
            a_nx      = a;
            b_nx      = b;
            pend_v_nx = pend_v;
            pend_nx   = pend;
            rsp_nx    = RSP_NONE;
            dat_nx    = dat;
            start     = 1'b0;
            start_pkt = pkt;
            case (state)
                IDLE: begin
                    if (new_req) start = 1'b1;
                end
                BUSY: begin
                    if (new_req) begin
                        pend_v_nx = 1'b1;
                        pend_nx   = pkt;
                    end
                    if (cnt == '0) begin
                        state_nx = DONE;
                        rsp_nx   = res_rsp;
                        dat_nx   = res_dat;
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // A request arriving now is newer than anything pending, so it wins.
                    if (new_req) begin
                        start = 1'b1;
                    end else if (pend_v) begin
                        start     = 1'b1;
                        start_pkt = pend;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (start) begin
                state_nx  = BUSY;
                cnt_nx    = CNT_W'(LATENCY - 1);
                op_nx     = cmd_t'(start_pkt[PKT_W-1 -: 2]);
                a_nx      = start_pkt[2*DATA_W-1:DATA_W];
                b_nx      = start_pkt[DATA_W-1:0];
                pend_v_nx = 1'b0;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                state  <= IDLE;
                cnt    <= '0;
                op     <= CMD_NOP;
                a      <= '0;
                b      <= '0;
                pend_v <= 1'b0;
                pend   <= '0;
                prev   <= '0;
                rsp    <= RSP_NONE;
                dat    <= '0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                op     <= op_nx;
                a      <= a_nx;
                b      <= b_nx;
                pend_v <= pend_v_nx;
                pend   <= pend_nx;
                prev   <= pkt;
                rsp    <= rsp_nx;
                dat    <= dat_nx;
            end
        end

        assign bus.output_packet[l] = {rsp, dat};
    end
endmodule

// File: tb/tb_alu_quad_bank.sv
// Randomized self-checking bench for alu_quad_bank against a transaction-level lane model.
module tb_alu_quad_bank;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = 32;
    localparam int LATENCY   = 3;

`ifdef ALU_SATURATE_EN
    localparam logic [31:0] ADD_OVF_DATA = 32'hFFFF_FFFF;
    localparam logic [31:0] MUL_OVF_DATA = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] ADD_OVF_DATA = 32'h0000_0001;
    localparam logic [31:0] MUL_OVF_DATA = 32'h0000_0000;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    alu_quad_bank_if #(.NUM_LANES(NUM_LANES), .DATA_W(DATA_W)) bus ();

    alu_quad_bank #(.NUM_LANES(NUM_LANES), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transaction-level model: each lane is free again at a known cycle, completes at a known cycle.
    int          t = 0;
    logic [65:0] m_prev     [NUM_LANES];
    int          m_free_at  [NUM_LANES];
    int          m_done_at  [NUM_LANES];
    bit          m_inflight [NUM_LANES];
    logic [33:0] m_result   [NUM_LANES];
    bit          m_pend_v   [NUM_LANES];
    logic [65:0] m_pend     [NUM_LANES];
    logic [1:0]  m_resp     [NUM_LANES];
    logic [31:0] m_data     [NUM_LANES];

    function automatic logic [33:0] alu_ref(input logic [65:0] p);
        logic [1:0]      c;
        logic [31:0]     x, y, d;
        logic [1:0]      r;
        longint unsigned wide;
        c = p[65:64];
        x = p[63:32];
        y = p[31:0];
        r = 2'd1;
        d = x & y;
        if (c == 2'd1 || c == 2'd2) begin
            if (c == 2'd1) wide = 64'(x) + 64'(y);
            else           wide = 64'(x) * 64'(y);
            d = wide[31:0];
            if (wide > 64'h0000_0000_FFFF_FFFF) begin
                r = 2'd2;
`ifdef ALU_SATURATE_EN
                d = 32'hFFFF_FFFF;
`endif
            end
        end
        return {r, d};
    endfunction

    task automatic model_start(input int l, input logic [65:0] p);
        m_result[l]   = alu_ref(p);
        m_done_at[l]  = t + LATENCY;
        m_free_at[l]  = t + LATENCY + 1;
        m_inflight[l] = 1'b1;
        m_pend_v[l]   = 1'b0;
    endtask

    task automatic model_edge();
        t++;
        for (int l = 0; l < NUM_LANES; l++) begin
            logic [65:0] p;
            logic        nreq;
            p = bus.input_packet[l];
            if (!reset) begin
                m_prev[l]     = '0;
                m_free_at[l]  = 0;
                m_inflight[l] = 1'b0;
                m_pend_v[l]   = 1'b0;
                m_resp[l]     = 2'd0;
                m_data[l]     = '0;
            end else begin
                nreq = (p[65:64] != 2'd0) && ((p != m_prev[l]) || (m_prev[l][65:64] == 2'd0));
                m_prev[l] = p;
                m_resp[l] = 2'd0;
                if (m_inflight[l] && t == m_done_at[l]) begin
                    m_resp[l]     = m_result[l][33:32];
                    m_data[l]     = m_result[l][31:0];
                    m_inflight[l] = 1'b0;
                end
                if (nreq) begin
                    if (t >= m_free_at[l]) model_start(l, p);
                    else begin
                        m_pend_v[l] = 1'b1;
                        m_pend[l]   = p;
                    end
                end else if (m_pend_v[l] && t >= m_free_at[l]) begin
                    model_start(l, m_pend[l]);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        for (int l = 0; l < NUM_LANES; l++)
            check($sformatf("lane%0d_t%0d", l, t), bus.output_packet[l], {m_resp[l], m_data[l]});
    endtask

    task automatic drive(input int l, input logic [1:0] c, input logic [31:0] x, input logic [31:0] y);
        bus.input_packet[l] = {c, x, y};
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 15));
            2:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: v = 32'(1) << $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    initial begin
        bus.input_packet = '0;
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();

        // All four lanes issued on one edge.
        drive(0, 2'd1, 32'h0000_0005, 32'h0000_0007);
        drive(1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        drive(2, 2'd2, 32'h0001_0000, 32'h0001_0000);
        drive(3, 2'd3, 32'hF0F0_F0F0, 32'h0FF0_FF00);
        cycle();
        cycle();
        cycle();
        check("early_lane0", bus.output_packet[0], 34'h0);
        cycle();
        check("add_ok",  bus.output_packet[0], {2'd1, 32'h0000_000C});
        check("add_ovf", bus.output_packet[1], {2'd2, ADD_OVF_DATA});
        check("mul_ovf", bus.output_packet[2], {2'd2, MUL_OVF_DATA});
        check("and_ok",  bus.output_packet[3], {2'd1, 32'h00F0_F000});
        cycle();
        check("pulse_end", bus.output_packet[0], {2'd0, 32'h0000_000C});

        // Held packets must not retrigger.
        repeat (20) cycle();
        check("hold_lane3", bus.output_packet[3], {2'd0, 32'h00F0_F000});

        drive(2, 2'd2, 32'd3, 32'd4);
        repeat (4) cycle();
        check("mul_ok", bus.output_packet[2], {2'd1, 32'd12});

        // Reset one cycle into a busy op aborts it.
        drive(0, 2'd1, 32'd100, 32'd200);
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        drive(0, 2'd0, 32'd0, 32'd0);
        repeat (3) cycle();
        check("rst_abort", bus.output_packet[0], 34'h0);

        for (int n = 0; n < 3000; n++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                int unsigned r;
                r = $urandom_range(0, 9);
                if (r < 2)       drive(l, 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
                else if (r == 2) drive(l, 2'd0, rand_operand(), rand_operand());
            end
            reset = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
